platform_scroll_scheduler: RTL and testbench



---
 rtl/platform_scroll_scheduler.sv | 156 +++++++++++++++
 tb/tb_platform_scroll_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/platform_scroll_scheduler.sv
// platform_scroll_scheduler
//   Owns the platform slot table (per-slot y/x plus activation mask). On each
//   accepted frame_tick it runs a SCROLL pass (shift every live platform down
//   by the latched delta, retire those that leave the screen) followed by a
//   SPAWN pass (refill retired slots above the topmost platform with an
//   LFSR-chosen x). Both passes visit one slot per cycle. After reset the
//   block performs an initial SPAWN fill without needing a tick.
//
//   Optional build macro: PLATFORM_JITTER_EN
//     defined   -> spawn gap is SPACING + lfsr[13:10] (0..15 extra pixels)
//     undefined -> spawn gap is exactly SPACING
//
// Ports
//   clk                  clock
//   rst                  synchronous, active-high reset
//   frame_tick           one-cycle request to run scroll+spawn (IDLE only)
//   scroll_dy[9:0]       unsigned downward scroll, latched on accepted tick
//   busy                 high while the table is being updated
//   done                 one-cycle pulse when a cycle completes
//   platforms            per slot: [i][0] = y (signed 11b), [i][1] = x (11b, >= 0)
//   platform_activation  per slot: 1 = live platform
//   top_y[11:0]          signed y of the most recently spawned platform

module platform_scroll_scheduler #(
    parameter int          N_PLAT    = 93,
    parameter int          SCREEN_H  = 768,
    parameter int          SPACING   = 96,
    parameter int          X_MAX     = 924,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         frame_tick,
    input  logic [9:0]                   scroll_dy,
    output logic                         busy,
    output logic                         done,
    output logic [N_PLAT-1:0][1:0][10:0] platforms,
    output logic [N_PLAT-1:0]            platform_activation,
    output logic [11:0]                  top_y
);

    localparam int IDX_W = (N_PLAT > 1) ? $clog2(N_PLAT) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(N_PLAT - 1);
    localparam logic signed [11:0] SCREEN_H_S = 12'(SCREEN_H);
    localparam logic signed [11:0] SPACING_S  = 12'(SPACING);
    localparam logic [9:0]         X_MAX_V    = 10'(X_MAX);
    localparam logic [9:0]         X_WRAP     = 10'(X_MAX + 1);

    typedef enum logic [1:0] {IDLE, SCROLL, SPAWN, DONE} state_t;

    state_t            state, state_next;
    logic [IDX_W-1:0]  idx, idx_next;
    logic [9:0]        dy_r;
    logic [15:0]       lfsr, lfsr_next;

    logic [10:0]        cur_y;
    logic               cur_act;
    logic signed [11:0] sum;
    logic signed [11:0] gap;
    logic signed [11:0] new_y;
    logic [9:0]         x_raw;
    logic [10:0]        xr;
    logic               last;
    logic               tick_accept, do_retire, do_move, do_spawn;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        tick_accept = 1'b0;
        do_retire   = 1'b0;
        do_move     = 1'b0;
        do_spawn    = 1'b0;

        cur_y   = platforms[idx][0];
        cur_act = platform_activation[idx];
        sum     = $signed({cur_y[10], cur_y}) + $signed({2'b00, dy_r});
        last    = (idx == LAST_IDX);

`ifdef PLATFORM_JITTER_EN
        gap = SPACING_S + $signed({8'b0, lfsr[13:10]});
`else
        gap = SPACING_S;
`endif
        new_y = $signed(top_y) - gap;

        // Galois LFSR, taps 0xB400, shifting right
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

        // Fold out-of-range 10-bit values back into 0..X_MAX
        x_raw = lfsr[9:0];
        if (x_raw <= X_MAX_V) xr = {1'b0, x_raw};
        else                  xr = {1'b0, x_raw - X_WRAP};

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    tick_accept = 1'b1;
                    idx_next    = '0;
                    state_next  = SCROLL;
                end
            end
            SCROLL: begin
                if (cur_act) begin
                    if (sum >= SCREEN_H_S) do_retire = 1'b1;
                    else                   do_move   = 1'b1;
                end
                if (last) begin
                    idx_next   = '0;
                    state_next = SPAWN;
                end else begin
                    idx_next = idx + 1'b1;
                end
            end
            SPAWN: begin
                do_spawn = !cur_act && ($signed(top_y) >= gap);
                if (last) state_next = DONE;
                else      idx_next   = idx + 1'b1;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= SPAWN;
            idx                 <= '0;
            dy_r                <= '0;
            lfsr                <= LFSR_SEED;
            top_y               <= 12'(SCREEN_H);
            platforms           <= '0;
            platform_activation <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (tick_accept) dy_r <= scroll_dy;
            // Camera delta is applied to top_y once per pass, on the first slot
            if (state == SCROLL && idx == '0) top_y <= top_y + {2'b00, dy_r};
            if (do_retire) platform_activation[idx] <= 1'b0;
            if (do_move)   platforms[idx][0] <= sum[10:0];
            if (do_spawn) begin
                platforms[idx][0]        <= new_y[10:0];
                platforms[idx][1]        <= xr;
                platform_activation[idx] <= 1'b1;
                top_y                    <= new_y;
                lfsr                     <= lfsr_next;
            end
        end
    end

endmodule

// File: tb/tb_platform_scroll_scheduler.sv
module tb_platform_scroll_scheduler;

    localparam int NP = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     frame_tick;
    logic [9:0]               scroll_dy;
    logic                     busy;
    logic                     done;
    logic [NP-1:0][1:0][10:0] platforms;
    logic [NP-1:0]            platform_activation;
    logic [11:0]              top_y;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;
    int          exp_y [NP];
    int          exp_x [NP];
    logic [NP-1:0] exp_act;
    int          exp_top;

    always #5 clk = ~clk;

    platform_scroll_scheduler #(
        .N_PLAT   (NP),
        .SCREEN_H (768),
        .SPACING  (96),
        .X_MAX    (924),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .frame_tick         (frame_tick),
        .scroll_dy          (scroll_dy),
        .busy               (busy),
        .done               (done),
        .platforms          (platforms),
        .platform_activation(platform_activation),
        .top_y              (top_y)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference x generator: x from the current state, then one LFSR step
    task automatic model_spawn(output int x);
        int v;
        v = int'(m_lfsr[9:0]);
        x = (v > 924) ? v - 925 : v;
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < NP; i++) begin
            check($sformatf("%s_y%0d", tag, i), {21'b0, platforms[i][0]}, exp_y[i]);
            check($sformatf("%s_x%0d", tag, i), {21'b0, platforms[i][1]}, exp_x[i]);
            check($sformatf("%s_act%0d", tag, i), {31'b0, platform_activation[i]}, {31'b0, exp_act[i]});
        end
        check({tag, "_top"}, {20'b0, top_y}, exp_top);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 1);
        check({tag, "_done"}, {31'b0, done}, 0);
        check({tag, "_act"}, {24'b0, platform_activation}, 0);
        check({tag, "_top"}, {20'b0, top_y}, 768);
        check({tag, "_plat0"}, {21'b0, platforms[0][0]}, 0);
        check({tag, "_plat7x"}, {21'b0, platforms[7][1]}, 0);
    endtask

    // Called in the first cycle after rst drops: expects 9 busy cycles,
    // done in the last, then the full table laid out from the top down.
    task automatic fill_check(input string tag);
        m_lfsr = 16'hACE1;
        for (int i = 0; i < NP; i++) begin
            exp_y[i] = 672 - 96 * i;
            model_spawn(exp_x[i]);
        end
        exp_act = '1;
        exp_top = 0;
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("%s_busy_c%0d", tag, c), {31'b0, busy}, 1);
            check($sformatf("%s_done_c%0d", tag, c), {31'b0, done}, (c == 9) ? 1 : 0);
            step();
        end
        check({tag, "_idle_busy"}, {31'b0, busy}, 0);
        check({tag, "_idle_done"}, {31'b0, done}, 0);
        check_table(tag);
    endtask

    task automatic run_frame(input string tag, input logic [9:0] dy);
        int n;
        frame_tick = 1'b1;
        scroll_dy  = dy;
        step();
        frame_tick = 1'b0;
        scroll_dy  = 10'h155;
        n = 1;
        while (!done && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, 17);
        check({tag, "_busy_at_done"}, {31'b0, busy}, 1);
        step();
        check({tag, "_busy_after"}, {31'b0, busy}, 0);
        check({tag, "_done_after"}, {31'b0, done}, 0);
    endtask

    initial begin
        int n;
        int dones;
        int done_at;

        rst        = 1'b1;
        frame_tick = 1'b0;
        scroll_dy  = '0;
        step();
        step();
        check_reset_state("rst");
        rst = 1'b0;

        // Cold-reset initial fill
        fill_check("fill");

        // Zero scroll: nothing retires, top_y stays below SPACING -> no spawn
        run_frame("dy0", 10'd0);
        check_table("dy0");

        // Maximum scroll: everything retires, refill from top_y = 1023
        run_frame("dy1023", 10'd1023);
        for (int i = 0; i < NP; i++) begin
            exp_y[i] = 927 - 96 * i;
            model_spawn(exp_x[i]);
        end
        exp_act = '1;
        exp_top = 255;
        check_table("dy1023");

        // Reset while SCROLL is on slot 3
        frame_tick = 1'b1;
        scroll_dy  = 10'd50;
        step();
        frame_tick = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        step();
        check_reset_state("midrst");
        rst = 1'b0;
        fill_check("refill");

        // Scroll 100: slot 0 falls off (772), respawns at y=4
        run_frame("dy100", 10'd100);
        for (int i = 1; i < NP; i++) exp_y[i] = 772 - 96 * i;
        exp_y[0] = 4;
        model_spawn(exp_x[0]);
        exp_act = '1;
        exp_top = 4;
        check_table("dy100");

        // Tick held through the whole busy window: only one pass may run
        frame_tick = 1'b1;
        scroll_dy  = 10'd0;
        step();
        n       = 1;
        dones   = 0;
        done_at = 0;
        while (busy && n < 60) begin
            if (done) begin
                dones++;
                done_at = n;
            end
            step();
            n++;
        end
        frame_tick = 1'b0;
        check("held_done_at", done_at, 17);
        for (int c = 0; c < 30; c++) begin
            if (done) dones++;
            step();
        end
        check("held_done_count", dones, 1);
        check("held_idle", {31'b0, busy}, 0);
        check_table("held");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
